// File: rtl/rtc_edit_sequencer.sv
// ============================================================================
// Module  : rtc_edit_sequencer
// Brief   : Field select, inc/dec strobes, wrap limits and commit handshake
//           for manual editing of RTC counters. Optional macro: LEAP_YEAR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rtc_edit_sequencer #(
  parameter int NUM_FIELDS  = 6,
  parameter int ACK_TIMEOUT = 255,
  parameter int TW          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  edit_mode,
  input  logic                  btn_up,
  input  logic                  btn_dn,
  input  logic                  btn_next,
  input  logic                  btn_prev,
  input  logic [6:0]            month_val,
  input  logic [6:0]            year_val,
  input  logic                  wr_ack,
  output logic [2:0]            field_sel,
  output logic [NUM_FIELDS-1:0] en_field,
  output logic                  inc_pulse,
  output logic                  dec_pulse,
  output logic [6:0]            condicion,
  output logic                  wr_req,
  output logic                  wr_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EDIT     = 2'd1,
    S_COMMIT   = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_t;

  localparam logic [2:0]    c_last_field = 3'(NUM_FIELDS - 1);
  localparam logic [TW-1:0] c_timeout    = TW'(ACK_TIMEOUT);

  // Input bit order: {prev, next, dn, up, edit}
  logic [4:0]    r_in_cur, r_in_prev;
  logic [4:0]    w_rise;
  logic          w_edit_fall;
  state_t        r_state, w_state_n;
  logic [2:0]    r_field, w_field_n;
  logic          r_err, w_err_n;
  logic [TW-1:0] r_cnt, w_cnt_n, w_cnt_inc;
  logic [6:0]    w_day_lim;

  // History resets high so a level held through reset yields no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_cur  <= '1;
      r_in_prev <= '1;
    end else begin
      r_in_cur  <= {btn_prev, btn_next, btn_dn, btn_up, edit_mode};
      r_in_prev <= r_in_cur;
    end
  end

  assign w_rise      = r_in_cur & ~r_in_prev;
  assign w_edit_fall = ~r_in_cur[0] & r_in_prev[0];
  assign w_cnt_inc   = r_cnt + TW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_field <= 3'd0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_field <= w_field_n;
      r_err   <= w_err_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_field_n = r_field;
    w_err_n   = r_err;
    w_cnt_n   = r_cnt;
    inc_pulse = 1'b0;
    dec_pulse = 1'b0;
    en_field  = '0;
    wr_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise[0]) begin
          w_state_n = S_EDIT;
          w_field_n = 3'd0;
          w_err_n   = 1'b0;
        end
      end
      S_EDIT: begin
        en_field = {{(NUM_FIELDS-1){1'b0}}, 1'b1} << r_field;
        if (w_edit_fall) begin
          w_state_n = S_COMMIT;
        end else if (w_rise[3] | w_rise[4]) begin
          // Navigation owns the cycle: no inc/dec strobes alongside it.
          if (w_rise[3] && !w_rise[4])
            w_field_n = (r_field == c_last_field) ? 3'd0 : r_field + 3'd1;
          else if (w_rise[4] && !w_rise[3])
            w_field_n = (r_field == 3'd0) ? c_last_field : r_field - 3'd1;
        end else begin
          inc_pulse = w_rise[1] & ~w_rise[2];
          dec_pulse = w_rise[2] & ~w_rise[1];
        end
      end
      S_COMMIT: begin
        wr_req    = 1'b1;
        w_cnt_n   = '0;
        w_state_n = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        wr_req = 1'b1;
        if (wr_ack) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end else if (w_cnt_inc == c_timeout) begin
          w_state_n = S_IDLE;
          w_err_n   = 1'b1;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = w_cnt_inc;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

`ifdef LEAP_YEAR_EN
  logic [6:0] w_feb_lim;
  assign w_feb_lim = (year_val[1:0] == 2'b00) ? 7'd29 : 7'd28;
`else
  logic [6:0] w_feb_lim;
  logic       w_unused_year;
  assign w_feb_lim     = 7'd29;
  assign w_unused_year = ^year_val;
`endif

  always_comb begin
    case (month_val)
      7'd4, 7'd6, 7'd9, 7'd11: w_day_lim = 7'd30;
      7'd2:                    w_day_lim = w_feb_lim;
      default:                 w_day_lim = 7'd31;
    endcase
  end

  always_comb begin
    case (r_field)
      3'd0, 3'd1: condicion = 7'd59;
      3'd2:       condicion = 7'd23;
      3'd3:       condicion = w_day_lim;
      3'd4:       condicion = 7'd12;
      3'd5:       condicion = 7'd99;
      default:    condicion = 7'd59;
    endcase
  end

  assign field_sel = r_field;
  assign wr_err    = r_err;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rtc_edit_sequencer.sv
// ============================================================================
// Module  : tb_rtc_edit_sequencer
// Brief   : Directed self-checking bench for rtc_edit_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rtc_edit_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       edit_mode, btn_up, btn_dn, btn_next, btn_prev, wr_ack;
  logic [6:0] month_val, year_val;
  logic [2:0] field_sel;
  logic [5:0] en_field;
  logic       inc_pulse, dec_pulse, wr_req, wr_err, busy;
  logic [6:0] condicion;

  int checks = 0;
  int errors = 0;

  rtc_edit_sequencer #(.NUM_FIELDS(6), .ACK_TIMEOUT(255), .TW(8)) dut (
    .clk(clk), .rst(rst), .edit_mode(edit_mode), .btn_up(btn_up),
    .btn_dn(btn_dn), .btn_next(btn_next), .btn_prev(btn_prev),
    .month_val(month_val), .year_val(year_val), .wr_ack(wr_ack),
    .field_sel(field_sel), .en_field(en_field), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .condicion(condicion), .wr_req(wr_req),
    .wr_err(wr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_up = 1'b1; btn_dn = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    edit_mode = 1'b0; wr_ack = 1'b0; month_val = 7'd1; year_val = 7'd24;
    step(3);
    rst = 1'b0;
    step(2);
    btn_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (inc_pulse !== 1'b0 || busy !== 1'b0 || wr_req !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet inc=%b busy=%b wr_req=%b expected 0 0 0", inc_pulse, busy, wr_req);
      end
    end
    checks++;
    if (condicion !== 7'd59 || field_sel !== 3'd0 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals cond=%0d field=%0d err=%b expected 59 0 0", condicion, field_sel, wr_err);
    end
  endtask

  task automatic test_idle_ignore;
    btn_up = 1'b1; wr_ack = 1'b1;
    step(1);
    wr_ack = 1'b0;
    step(1);
    checks++;
    if (inc_pulse !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore inc=%b busy=%b expected 0 0", inc_pulse, busy);
    end
    btn_up = 1'b0;
    step(2);
  endtask

  task automatic test_edit_inc;
    edit_mode = 1'b1;
    step(2);
    checks++;
    if (busy !== 1'b1 || field_sel !== 3'd0 || en_field !== 6'b000001) begin
      errors++;
      $display("FAIL edit_entry busy=%b field=%0d en=%b expected 1 0 000001", busy, field_sel, en_field);
    end
    btn_up = 1'b1;
    step(1);
    checks++;
    if (inc_pulse !== 1'b1 || dec_pulse !== 1'b0) begin
      errors++;
      $display("FAIL inc_pulse inc=%b dec=%b expected 1 0", inc_pulse, dec_pulse);
    end
    step(1);
    checks++;
    if (inc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL inc_width inc=%b expected 0", inc_pulse);
    end
    btn_up = 1'b0; btn_dn = 1'b1;
    step(1);
    checks++;
    if (dec_pulse !== 1'b1 || inc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL dec_pulse inc=%b dec=%b expected 0 1", inc_pulse, dec_pulse);
    end
    btn_dn = 1'b0;
    step(2);
    btn_up = 1'b1; btn_dn = 1'b1;
    step(1);
    checks++;
    if (inc_pulse !== 1'b0 || dec_pulse !== 1'b0) begin
      errors++;
      $display("FAIL up_dn_same inc=%b dec=%b expected 0 0", inc_pulse, dec_pulse);
    end
    btn_up = 1'b0; btn_dn = 1'b0;
    step(2);
  endtask

  task automatic test_field_nav;
    btn_prev = 1'b1;
    step(2);
    checks++;
    if (field_sel !== 3'd5 || condicion !== 7'd99 || en_field !== 6'b100000) begin
      errors++;
      $display("FAIL prev_wrap field=%0d cond=%0d en=%b expected 5 99 100000", field_sel, condicion, en_field);
    end
    btn_prev = 1'b0;
    step(1);
    for (int i = 0; i < 6; i++) begin
      btn_next = 1'b1; step(1);
      btn_next = 1'b0; step(1);
    end
    step(1);
    checks++;
    if (field_sel !== 3'd5) begin
      errors++;
      $display("FAIL next_x6 field=%0d expected 5", field_sel);
    end
    btn_next = 1'b1; btn_up = 1'b1;
    step(1);
    checks++;
    if (inc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL nav_suppress inc=%b expected 0", inc_pulse);
    end
    step(1);
    checks++;
    if (field_sel !== 3'd0 || condicion !== 7'd59) begin
      errors++;
      $display("FAIL next_wrap field=%0d cond=%0d expected 0 59", field_sel, condicion);
    end
    btn_next = 1'b0; btn_up = 1'b0;
    step(1);
    btn_next = 1'b1; btn_prev = 1'b1;
    step(2);
    checks++;
    if (field_sel !== 3'd0) begin
      errors++;
      $display("FAIL next_prev_same field=%0d expected 0", field_sel);
    end
    btn_next = 1'b0; btn_prev = 1'b0;
    step(1);
    for (int i = 0; i < 2; i++) begin
      btn_next = 1'b1; step(1);
      btn_next = 1'b0; step(1);
    end
    step(1);
    checks++;
    if (field_sel !== 3'd2 || condicion !== 7'd23) begin
      errors++;
      $display("FAIL hour_limit field=%0d cond=%0d expected 2 23", field_sel, condicion);
    end
    btn_next = 1'b1; step(1);
    btn_next = 1'b0; step(2);
  endtask

  task automatic test_condicion;
    logic [6:0] exp_nonleap;
`ifdef LEAP_YEAR_EN
    exp_nonleap = 7'd28;
`else
    exp_nonleap = 7'd29;
`endif
    month_val = 7'd2; year_val = 7'd24;
    step(1);
    checks++;
    if (field_sel !== 3'd3 || condicion !== 7'd29) begin
      errors++;
      $display("FAIL feb_leap field=%0d cond=%0d expected 3 29", field_sel, condicion);
    end
    year_val = 7'd23;
    step(1);
    checks++;
    if (condicion !== exp_nonleap) begin
      errors++;
      $display("FAIL feb_nonleap cond=%0d expected %0d", condicion, exp_nonleap);
    end
    month_val = 7'd4;  step(1);
    checks++;
    if (condicion !== 7'd30) begin
      errors++;
      $display("FAIL apr_limit cond=%0d expected 30", condicion);
    end
    month_val = 7'd11; step(1);
    checks++;
    if (condicion !== 7'd30) begin
      errors++;
      $display("FAIL nov_limit cond=%0d expected 30", condicion);
    end
    month_val = 7'd1;  step(1);
    checks++;
    if (condicion !== 7'd31) begin
      errors++;
      $display("FAIL jan_limit cond=%0d expected 31", condicion);
    end
    month_val = 7'd13; step(1);
    checks++;
    if (condicion !== 7'd31) begin
      errors++;
      $display("FAIL bad_month cond=%0d expected 31", condicion);
    end
    btn_next = 1'b1; step(1);
    btn_next = 1'b0; step(1);
    checks++;
    if (field_sel !== 3'd4 || condicion !== 7'd12) begin
      errors++;
      $display("FAIL month_limit field=%0d cond=%0d expected 4 12", field_sel, condicion);
    end
  endtask

  task automatic test_commit_ack;
    edit_mode = 1'b0; btn_up = 1'b1;
    step(1);
    checks++;
    if (inc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL fall_wins inc=%b expected 0", inc_pulse);
    end
    step(1);
    checks++;
    if (wr_req !== 1'b1 || en_field !== 6'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL commit wr_req=%b en=%b busy=%b expected 1 000000 1", wr_req, en_field, busy);
    end
    btn_up = 1'b0;
    step(10);
    checks++;
    if (wr_req !== 1'b1) begin
      errors++;
      $display("FAIL wait_hold wr_req=%b expected 1", wr_req);
    end
    wr_ack = 1'b1;
    step(1);
    wr_ack = 1'b0;
    checks++;
    if (wr_req !== 1'b0 || busy !== 1'b0 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL ack_done wr_req=%b busy=%b err=%b expected 0 0 0", wr_req, busy, wr_err);
    end
    step(2);
  endtask

  task automatic test_timeout;
    int hi_cycles;
    edit_mode = 1'b1; step(3);
    edit_mode = 1'b0;
    hi_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (wr_req === 1'b1) hi_cycles++;
      else if (hi_cycles > 0) break;
    end
    checks++;
    if (hi_cycles !== 256 || wr_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_len wr_req_cycles=%0d wr_req=%b expected 256 0", hi_cycles, wr_req);
    end
    checks++;
    if (wr_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err err=%b busy=%b expected 1 0", wr_err, busy);
    end
    edit_mode = 1'b1; step(2);
    checks++;
    if (wr_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_clear err=%b busy=%b expected 0 1", wr_err, busy);
    end
    edit_mode = 1'b0; step(5);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (wr_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst wr_req=%b busy=%b expected 0 0", wr_req, busy);
    end
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_edit_inc();
    test_field_nav();
    test_condicion();
    test_commit_ack();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
